// File: rtl/cache_fill_fsm_pkg.sv
// Shared CPU definitions for the cache miss fill engine: block geometry,
// fill-target select encoding and the fill FSM state type.
package cache_fill_fsm_pkg;

   localparam int WORDS_PER_BLOCK = 8;                    // 16-bit words per block
   localparam int CNT_W           = $clog2(WORDS_PER_BLOCK);
   localparam int OFF_W           = CNT_W + 1;            // byte-offset bits inside a block

   localparam logic FILL_SEL_I = 1'b0;                    // filling the I-cache
   localparam logic FILL_SEL_D = 1'b1;                    // filling the D-cache

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up counter with enable, synchronous clear and an all-ones terminal-count
// flag. The count wraps naturally to zero after the terminal value.
module fill_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_count;

   // Count register: clear has priority over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_tc    = &r_count;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine. On an I- or D-cache miss it streams one word
// request per cycle for the whole block, counts the pipelined memory returns,
// strobes each returned word into the selected data array and writes the tag
// with the final word. The design does not depend on the memory latency: it
// simply waits in WAIT until the last return arrives.
module cache_fill_fsm
   import cache_fill_fsm_pkg::*;
#(
   parameter int WPB    = WORDS_PER_BLOCK,
   parameter int ADDR_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    dmiss,
   input  logic [ADDR_W-1:0]       dmiss_addr,
   input  logic                    imiss,
   input  logic [ADDR_W-1:0]       imiss_addr,
   input  logic                    mem_valid,
   output logic                    mem_req,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic                    fill_busy,
   output logic                    fill_sel,
   output logic                    data_we,
   output logic [$clog2(WPB)-1:0]  word_idx,
   output logic                    tag_we
);

   localparam int CW = $clog2(WPB);
   localparam int OW = CW + 1;

   fill_state_t        r_state;
   fill_state_t        w_state_next;
   logic [ADDR_W-1:OW] r_base;
   logic               r_fill_sel;

   logic [CW-1:0]      w_issue_cnt;
   logic               w_issue_tc;
   logic [CW-1:0]      w_recv_cnt;
   logic               w_recv_tc;
   logic               w_in_fill;
   logic               w_ret;
   logic               w_unused_bits;

   assign w_in_fill = (r_state != ST_IDLE);
   // Returns only count while a fill is active; stray mem_valid in IDLE is dropped.
   assign w_ret     = w_in_fill & mem_valid;
   // Block-offset bits of the miss addresses are intentionally discarded.
   assign w_unused_bits = ^{dmiss_addr[OW-1:0], imiss_addr[OW-1:0]};

   fill_counter #(.WIDTH(CW)) u_issue_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (r_state == ST_IDLE),
      .i_en    (r_state == ST_REQ),
      .o_count (w_issue_cnt),
      .o_tc    (w_issue_tc)
   );

   fill_counter #(.WIDTH(CW)) u_recv_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (r_state == ST_IDLE),
      .i_en    (w_ret),
      .o_count (w_recv_cnt),
      .o_tc    (w_recv_tc)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Capture block base and target cache when a miss is accepted; D wins ties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base     <= '0;
         r_fill_sel <= FILL_SEL_I;
      end else if (r_state == ST_IDLE) begin
         if (dmiss) begin
            r_base     <= dmiss_addr[ADDR_W-1:OW];
            r_fill_sel <= FILL_SEL_D;
         end else if (imiss) begin
            r_base     <= imiss_addr[ADDR_W-1:OW];
            r_fill_sel <= FILL_SEL_I;
         end
      end
   end

   // Next-state and strobe decode; the final return ends the fill from either busy state.
   always_comb begin
      w_state_next = r_state;
      mem_req      = 1'b0;
      data_we      = 1'b0;
      tag_we       = 1'b0;
      case (r_state)
         ST_IDLE: if (dmiss || imiss) w_state_next = ST_REQ;
         ST_REQ: begin
            mem_req = 1'b1;
            if (w_issue_tc) w_state_next = ST_WAIT;
         end
         ST_WAIT: ;
         default: w_state_next = ST_IDLE;
      endcase
      if (w_ret) begin
         data_we = 1'b1;
         if (w_recv_tc) begin
            tag_we       = 1'b1;
            w_state_next = ST_IDLE;
         end
      end
   end

   // Request address stays inside the block: base concatenated with word offset.
   assign mem_addr  = mem_req ? {r_base, w_issue_cnt, 1'b0} : '0;
   assign word_idx  = w_recv_cnt;
   assign fill_busy = w_in_fill;
   assign fill_sel  = r_fill_sel;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a pipelined latency-4 memory model.
module tb_cache_fill_fsm;

   localparam int MEM_LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dmiss, imiss, mem_valid;
   logic [15:0] dmiss_addr, imiss_addr;
   logic        mem_req, fill_busy, fill_sel, data_we, tag_we;
   logic [15:0] mem_addr;
   logic [2:0]  word_idx;

   logic [MEM_LAT-1:0] r_pipe = '0;
   logic               r_force = 1'b0;
   int                 n_checks = 0;
   int                 n_errors = 0;

   cache_fill_fsm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dmiss      (dmiss),
      .dmiss_addr (dmiss_addr),
      .imiss      (imiss),
      .imiss_addr (imiss_addr),
      .mem_valid  (mem_valid),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .fill_busy  (fill_busy),
      .fill_sel   (fill_sel),
      .data_we    (data_we),
      .word_idx   (word_idx),
      .tag_we     (tag_we)
   );

   always #5 clk = ~clk;

   // Memory model: every request returns exactly MEM_LAT cycles later, regardless of reset.
   always @(posedge clk) r_pipe <= {r_pipe[MEM_LAT-2:0], mem_req};
   assign mem_valid = r_pipe[MEM_LAT-1] | r_force;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Checks one fill cycle by cycle. Caller raises the miss at the negedge of cycle 0.
   // The miss is dropped at drop_cyc (cache sees the hit); abort_cyc>0 returns early.
   task automatic do_fill(input logic [15:0] exp_base, input logic exp_sel,
                          input int drop_cyc, input int abort_cyc);
      int tags = 0;
      for (int cyc = 1; cyc <= 13; cyc++) begin
         @(negedge clk);
         check("fill_busy", fill_busy, cyc <= 12);
         check("mem_req", mem_req, cyc <= 8);
         if (cyc <= 8) check("mem_addr", mem_addr, exp_base + 16'(2 * (cyc - 1)));
         check("data_we", data_we, cyc >= 5 && cyc <= 12);
         if (cyc >= 5 && cyc <= 12) check("word_idx", word_idx, cyc - 5);
         check("tag_we", tag_we, cyc == 12);
         if (cyc <= 12) check("fill_sel", fill_sel, exp_sel);
         if (tag_we) tags++;
         if (cyc == drop_cyc) begin
            if (exp_sel) dmiss = 1'b0;
            else         imiss = 1'b0;
         end
         if (cyc == abort_cyc) begin
            $display("fill base=0x%04h sel=%0d aborted at cycle %0d", exp_base, exp_sel, cyc);
            return;
         end
      end
      check("tag_count", tags, 1);
      $display("fill base=0x%04h sel=%0d done", exp_base, exp_sel);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; dmiss = 1'b0; imiss = 1'b0;
      dmiss_addr = '0; imiss_addr = '0;

      // Reset state
      idle(2);
      check("rst_busy", fill_busy, 0);
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_sel", fill_sel, 0);
      check("rst_we", {data_we, tag_we}, 0);
      check("rst_idx", word_idx, 0);
      rst_n = 1'b1;
      idle(2);

      // 1: single D miss, unaligned address
      dmiss = 1'b1; dmiss_addr = 16'h1236;
      do_fill(16'h1230, 1'b1, 13, 0);
      idle(2);

      // 2: simultaneous misses, D first then I after one IDLE cycle
      dmiss = 1'b1; dmiss_addr = 16'h4000;
      imiss = 1'b1; imiss_addr = 16'h00A0;
      do_fill(16'h4000, 1'b1, 13, 0);
      do_fill(16'h00A0, 1'b0, 13, 0);
      idle(2);

      // 3: one-cycle dmiss pulse still completes the fill
      dmiss = 1'b1; dmiss_addr = 16'h7F48;
      do_fill(16'h7F40, 1'b1, 1, 0);
      idle(3);
      check("pulse_idle", fill_busy, 0);

      // 4: reset in cycle 7, stale returns must be ignored
      dmiss = 1'b1; dmiss_addr = 16'h2000;
      do_fill(16'h2000, 1'b1, 0, 7);
      rst_n = 1'b0; dmiss = 1'b0;
      #1;
      check("arst_busy", fill_busy, 0);
      check("arst_req", mem_req, 0);
      check("arst_we", {data_we, tag_we}, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("arst_stale_we", {data_we, tag_we, fill_busy}, 0);
      end
      rst_n = 1'b1;
      dmiss = 1'b1; dmiss_addr = 16'h2010;
      do_fill(16'h2010, 1'b1, 13, 0);
      idle(2);

      // 5: mem_valid while IDLE is ignored
      r_force = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_valid_we", {data_we, tag_we, fill_busy}, 0);
         check("idle_valid_idx", word_idx, 0);
      end
      r_force = 1'b0;
      imiss = 1'b1; imiss_addr = 16'h0100;
      do_fill(16'h0100, 1'b0, 13, 0);
      idle(1);

      // 6: I fill at the top of the traced region
      imiss = 1'b1; imiss_addr = 16'h013E;
      do_fill(16'h0130, 1'b0, 13, 0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
